// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stage enables, flushes, PC select,
// load-use bubbles, halt handling and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int RW    = 5,
    parameter int LDLAT = 1,
    parameter int CW    = 16
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          ihit,
    input  logic          dhit,
    input  logic          meldst,
    input  logic          exld,
    input  logic [RW-1:0] rs,
    input  logic [RW-1:0] rt,
    input  logic [RW-1:0] exrdst,
    input  logic [RW-1:0] merdst,
    input  logic [2:0]    pcsrc,
    input  logic          equal,
    input  logic          halt,
    output logic          pcen,
    output logic          deen,
    output logic          exen,
    output logic          meen,
    output logic          wben,
    output logic          deflush,
    output logic          exflush,
    output logic          meflush,
    output logic [1:0]    pcsel,
    output logic          halted,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, LDSTALL, HALTED} state_e;

    localparam logic [1:0] BUB_INIT = 2'((LDLAT > 1) ? (LDLAT - 2) : 0);

    state_e        state_q, state_d;
    logic [2:0]    r_pcsrc_q, r_pcsrc_d;
    logic [1:0]    bub_q, bub_d;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic [CW-1:0] flush_cnt_q, flush_cnt_d;
    logic          ld_use, jr_ld, br_taken;

    // Hazard and branch-outcome detection; r0 never creates a dependency
    always_comb begin
        ld_use   = exld && (exrdst != '0) &&
                   ((rs == exrdst) || (rt == exrdst));
        jr_ld    = (pcsrc == 3'd1) && exld &&
                   (merdst != '0) && (rs == merdst);
        br_taken = ((r_pcsrc_q == 3'd3) && equal) ||
                   ((r_pcsrc_q == 3'd4) && !equal);
    end

    // Priority-ordered enable/flush decision and next-state selection
    always_comb begin
        pcen    = ihit;
        deen    = ihit;
        exen    = ihit;
        meen    = ihit;
        wben    = ihit;
        deflush = 1'b0;
        exflush = 1'b0;
        meflush = 1'b0;
        pcsel   = 2'd0;
        state_d = state_q;
        bub_d   = bub_q;
        if (state_q == HALTED) begin
            {pcen, deen, exen, meen, wben} = '0;
        end else if (halt) begin
            {pcen, deen, exen, meen} = '0;
            wben    = 1'b1;
            state_d = HALTED;
        end else if (meldst && !dhit) begin
            {pcen, deen, exen, meen, wben} = '0;
        end else if (meldst && !ihit) begin
            {pcen, deen, exen, meen} = '0;
            wben    = 1'b1;
            meflush = 1'b1;
        end else if (state_q == LDSTALL) begin
            {pcen, deen, exen} = '0;
            exflush = ihit;
            if (ihit) begin
                if (bub_q == 2'd0) state_d = RUN;
                else bub_d = bub_q - 2'd1;
            end
        end else if (ld_use) begin
            {pcen, deen, exen} = '0;
            exflush = ihit;
            if ((LDLAT > 1) && ihit) begin
                state_d = LDSTALL;
                bub_d   = BUB_INIT;
            end
        end else if (jr_ld) begin
            {pcen, deen, exen} = '0;
            exflush = ihit;
        end else if (br_taken) begin
            pcsel   = 2'd3;
            deen    = 1'b0;
            exen    = 1'b0;
            deflush = ihit;
            exflush = ihit;
        end else if (pcsrc == 3'd2) begin
            pcsel   = 2'd2;
            deen    = 1'b0;
            deflush = ihit;
        end else if (pcsrc == 3'd1) begin
            pcsel   = 2'd1;
            deen    = 1'b0;
            deflush = ihit;
        end
    end

    // Flow-type capture and saturating performance counters
    always_comb begin
        r_pcsrc_d   = (ihit && pcen) ? pcsrc : r_pcsrc_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pcen && (state_q != HALTED) && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CW'(1);
        if ((deflush || exflush || meflush) && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CW'(1);
    end

    // State and counter registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= RUN;
            r_pcsrc_q   <= 3'd0;
            bub_q       <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            r_pcsrc_q   <= r_pcsrc_d;
            bub_q       <= bub_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign halted    = (state_q == HALTED);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios on two parameterisations
// plus randomized traffic checked against a rule-level model.
module tb_hazard_ctrl;

    localparam logic [10:0] V_IDLE  = 11'b11111_000_00_0;
    localparam logic [10:0] V_STALL = 11'b00011_010_00_0;
    localparam logic [10:0] V_ZERO  = 11'b00000_000_00_0;
    localparam logic [10:0] V_HLTD  = 11'b00000_000_00_1;
    localparam logic [10:0] V_HCYC  = 11'b00001_000_00_0;
    localparam logic [10:0] V_MEMF  = 11'b00001_001_00_0;
    localparam logic [10:0] V_BR    = 11'b10011_110_11_0;
    localparam logic [10:0] V_J     = 11'b10111_100_10_0;
    localparam logic [10:0] V_JR    = 11'b10111_100_01_0;

    typedef struct {
        int st;
        int rp;
        int bub;
        int sc;
        int fc;
    } ms_t;

    logic       CLK, nRST;
    logic       ihit, dhit, meldst, exld, equal, halt;
    logic [4:0] rs, rt, exrdst, merdst;
    logic [2:0] pcsrc;

    wire [10:0] oa, ob;
    wire [15:0] sca, fca;
    wire [1:0]  scb, fcb;

    int vecs = 0;
    int errs = 0;

    hazard_ctrl #(.RW(5), .LDLAT(2), .CW(16)) u_a (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .meldst(meldst), .exld(exld), .rs(rs), .rt(rt),
        .exrdst(exrdst), .merdst(merdst), .pcsrc(pcsrc),
        .equal(equal), .halt(halt),
        .pcen(oa[10]), .deen(oa[9]), .exen(oa[8]), .meen(oa[7]),
        .wben(oa[6]), .deflush(oa[5]), .exflush(oa[4]),
        .meflush(oa[3]), .pcsel(oa[2:1]), .halted(oa[0]),
        .stall_cnt(sca), .flush_cnt(fca)
    );

    hazard_ctrl #(.RW(5), .LDLAT(3), .CW(2)) u_b (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .meldst(meldst), .exld(exld), .rs(rs), .rt(rt),
        .exrdst(exrdst), .merdst(merdst), .pcsrc(pcsrc),
        .equal(equal), .halt(halt),
        .pcen(ob[10]), .deen(ob[9]), .exen(ob[8]), .meen(ob[7]),
        .wben(ob[6]), .deflush(ob[5]), .exflush(ob[4]),
        .meflush(ob[3]), .pcsel(ob[2:1]), .halted(ob[0]),
        .stall_cnt(scb), .flush_cnt(fcb)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic idle();
        ihit = 1'b1; dhit = 1'b1; meldst = 1'b0; exld = 1'b0;
        rs = '0; rt = '0; exrdst = '0; merdst = '0;
        pcsrc = 3'd0; equal = 1'b0; halt = 1'b0;
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic rst_pulse();
        idle();
        nRST = 1'b0;
        #1;
        nRST = 1'b1;
    endtask

    // Rule-level reference: st 0=run 1=load-stall 2=halted
    function automatic void mdl(input ms_t s, input int ldlat,
                                input int cw, output logic [10:0] o,
                                output ms_t n);
        logic pe, de, ee, me, we, df, ef, mf, h;
        logic [1:0] ps;
        bit lu, jl, tk;
        int maxc;
        maxc = (1 << cw) - 1;
        n = s;
        {pe, de, ee, me, we} = {5{ihit}};
        {df, ef, mf, h} = '0;
        ps = 2'd0;
        lu = exld && exrdst != 0 && (rs == exrdst || rt == exrdst);
        jl = pcsrc == 1 && exld && rs == merdst && merdst != 0;
        tk = (s.rp == 3 && equal) || (s.rp == 4 && !equal);
        if (s.st == 2) begin
            {pe, de, ee, me, we} = '0;
            h = 1'b1;
        end else if (halt) begin
            {pe, de, ee, me, we} = 5'b00001;
            n.st = 2;
        end else if (meldst && !dhit) begin
            {pe, de, ee, me, we} = '0;
        end else if (meldst && !ihit) begin
            {pe, de, ee, me, we} = 5'b00001;
            mf = 1'b1;
        end else if (s.st == 1) begin
            {pe, de, ee} = '0;
            ef = ihit;
            if (ihit) begin
                if (s.bub == 0) n.st = 0;
                else n.bub = s.bub - 1;
            end
        end else if (lu) begin
            {pe, de, ee} = '0;
            ef = ihit;
            if (ldlat > 1 && ihit) begin
                n.st = 1;
                n.bub = ldlat - 2;
            end
        end else if (jl) begin
            {pe, de, ee} = '0;
            ef = ihit;
        end else if (tk) begin
            ps = 2'd3; de = 0; ee = 0; df = ihit; ef = ihit;
        end else if (pcsrc == 2) begin
            ps = 2'd2; de = 0; df = ihit;
        end else if (pcsrc == 1) begin
            ps = 2'd1; de = 0; df = ihit;
        end
        if (ihit && pe) n.rp = int'(pcsrc);
        if (!pe && s.st != 2) n.sc = (s.sc < maxc) ? s.sc + 1 : maxc;
        if (df || ef || mf) n.fc = (s.fc < maxc) ? s.fc + 1 : maxc;
        o = {pe, de, ee, me, we, df, ef, mf, ps, h};
    endfunction

    task automatic test_reset();
        idle();
        nRST = 1'b0;
        cyc(); cyc();
        #2;
        vecs++; if (oa !== V_IDLE) begin errs++;
            $display("FAIL rst_out_a got=%b exp=%b", oa, V_IDLE); end
        vecs++; if (ob !== V_IDLE) begin errs++;
            $display("FAIL rst_out_b got=%b exp=%b", ob, V_IDLE); end
        vecs++; if ({sca, fca} !== 32'd0) begin errs++;
            $display("FAIL rst_cnt_a got=%0d/%0d exp=0/0", sca, fca); end
        pcsrc = 3'd2;
        #1;
        vecs++; if (oa !== V_J) begin errs++;
            $display("FAIL rst_comb got=%b exp=%b", oa, V_J); end
        cyc();
        #2;
        vecs++; if ({sca, fca, scb, fcb} !== 36'd0) begin errs++;
            $display("FAIL rst_hold got=%0d/%0d exp=0/0", sca, fca); end
        pcsrc = 3'd0;
        nRST = 1'b1;
        cyc();
    endtask

    task automatic test_load_use();
        rst_pulse();
        exld = 1'b1; exrdst = 5'd8; rs = 5'd8;
        #2;
        vecs++; if (oa !== V_STALL) begin errs++;
            $display("FAIL lu_c1 got=%b exp=%b", oa, V_STALL); end
        cyc();
        exld = 1'b0;
        #2;
        vecs++; if ({oa, ob} !== {V_STALL, V_STALL}) begin errs++;
            $display("FAIL lu_c2 got=%b/%b exp=%b", oa, ob, V_STALL); end
        cyc();
        #2;
        vecs++; if ({oa, ob} !== {V_IDLE, V_STALL}) begin errs++;
            $display("FAIL lu_c3 got=%b/%b exp=%b/%b",
                     oa, ob, V_IDLE, V_STALL); end
        vecs++; if (sca !== 16'd2) begin errs++;
            $display("FAIL lu_stall_cnt got=%0d exp=2", sca); end
        cyc();
        #2;
        vecs++; if (ob !== V_IDLE) begin errs++;
            $display("FAIL lu_b_done got=%b exp=%b", ob, V_IDLE); end
        vecs++; if ({sca, fca, scb} !== {16'd2, 16'd2, 2'd3}) begin errs++;
            $display("FAIL lu_cnts got=%0d/%0d/%0d exp=2/2/3",
                     sca, fca, scb); end
        cyc();
    endtask

    task automatic test_zero_reg();
        rst_pulse();
        exld = 1'b1; exrdst = 5'd0; rs = 5'd0; rt = 5'd0;
        #2;
        vecs++; if ({oa, ob} !== {V_IDLE, V_IDLE}) begin errs++;
            $display("FAIL zero_reg got=%b exp=%b", oa, V_IDLE); end
        cyc();
        rs = 5'd3; rt = 5'd9; exrdst = 5'd9;
        #2;
        vecs++; if (oa !== V_STALL) begin errs++;
            $display("FAIL rt_hazard got=%b exp=%b", oa, V_STALL); end
        cyc();
        idle();
        cyc(); cyc(); cyc();
        ihit = 1'b0; exld = 1'b1; exrdst = 5'd5; rs = 5'd5;
        #2;
        vecs++; if ({oa, ob} !== {V_ZERO, V_ZERO}) begin errs++;
            $display("FAIL nohit_haz got=%b exp=%b", oa, V_ZERO); end
        cyc();
        exld = 1'b0; ihit = 1'b1;
        #2;
        vecs++; if ({oa, ob} !== {V_IDLE, V_IDLE}) begin errs++;
            $display("FAIL nohit_nostate got=%b/%b exp=%b",
                     oa, ob, V_IDLE); end
        cyc();
    endtask

    task automatic test_branch();
        rst_pulse();
        pcsrc = 3'd3;
        #2;
        vecs++; if (oa !== V_IDLE) begin errs++;
            $display("FAIL beq_dec got=%b exp=%b", oa, V_IDLE); end
        cyc();
        pcsrc = 3'd0; equal = 1'b1;
        #2;
        vecs++; if ({oa, fca} !== {V_BR, 16'd0}) begin errs++;
            $display("FAIL beq_taken got=%b/%0d exp=%b/0", oa, fca, V_BR); end
        cyc();
        pcsrc = 3'd4;
        #2;
        vecs++; if ({oa, fca} !== {V_IDLE, 16'd1}) begin errs++;
            $display("FAIL beq_after got=%b/%0d exp=%b/1",
                     oa, fca, V_IDLE); end
        cyc();
        #2;
        vecs++; if (oa !== V_IDLE) begin errs++;
            $display("FAIL bne_nt got=%b exp=%b", oa, V_IDLE); end
        cyc();
        pcsrc = 3'd0; equal = 1'b0;
        #2;
        vecs++; if (oa !== V_BR) begin errs++;
            $display("FAIL bne_taken got=%b exp=%b", oa, V_BR); end
        cyc();
        #2;
        vecs++; if (fca !== 16'd2) begin errs++;
            $display("FAIL br_flush_cnt got=%0d exp=2", fca); end
        cyc();
    endtask

    task automatic test_jump();
        rst_pulse();
        pcsrc = 3'd2;
        #2;
        vecs++; if ({oa, ob} !== {V_J, V_J}) begin errs++;
            $display("FAIL jmp got=%b exp=%b", oa, V_J); end
        cyc();
        pcsrc = 3'd1;
        #2;
        vecs++; if (oa !== V_JR) begin errs++;
            $display("FAIL jr got=%b exp=%b", oa, V_JR); end
        cyc();
        exld = 1'b1; rs = 5'd6; merdst = 5'd6; exrdst = 5'd7;
        #2;
        vecs++; if ({oa, ob} !== {V_STALL, V_STALL}) begin errs++;
            $display("FAIL jr_load got=%b exp=%b", oa, V_STALL); end
        cyc();
        exld = 1'b0;
        #2;
        vecs++; if ({oa, ob} !== {V_JR, V_JR}) begin errs++;
            $display("FAIL jr_resume got=%b exp=%b", oa, V_JR); end
        cyc();
        idle();
    endtask

    task automatic test_mem_stall();
        rst_pulse();
        meldst = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            vecs++; if ({oa, ob} !== {V_ZERO, V_ZERO}) begin errs++;
                $display("FAIL mem_wait%0d got=%b exp=%b", i, oa, V_ZERO); end
            cyc();
        end
        dhit = 1'b1; ihit = 1'b0;
        #2;
        vecs++; if (oa !== V_MEMF) begin errs++;
            $display("FAIL mem_done got=%b exp=%b", oa, V_MEMF); end
        cyc();
        dhit = 1'b0; ihit = 1'b1;
        #2;
        vecs++; if ({sca, scb, fca} !== {16'd4, 2'd3, 16'd1}) begin errs++;
            $display("FAIL mem_cnt got=%0d/%0d/%0d exp=4/3/1",
                     sca, scb, fca); end
        cyc();
        idle();
        #2;
        vecs++; if ({sca, scb} !== {16'd5, 2'd3}) begin errs++;
            $display("FAIL sat_cnt got=%0d/%0d exp=5/3", sca, scb); end
        cyc();
    endtask

    task automatic test_halt();
        rst_pulse();
        halt = 1'b1;
        #2;
        vecs++; if (oa !== V_HCYC) begin errs++;
            $display("FAIL halt_cyc got=%b exp=%b", oa, V_HCYC); end
        cyc();
        halt = 1'b0; pcsrc = 3'd2;
        #2;
        vecs++; if ({oa, ob} !== {V_HLTD, V_HLTD}) begin errs++;
            $display("FAIL halted got=%b exp=%b", oa, V_HLTD); end
        cyc();
        exld = 1'b1; exrdst = 5'd3; rs = 5'd3;
        cyc();
        #2;
        vecs++; if ({oa, sca, fca} !== {V_HLTD, 16'd1, 16'd0}) begin errs++;
            $display("FAIL halt_hold got=%b/%0d/%0d exp=%b/1/0",
                     oa, sca, fca, V_HLTD); end
        idle();
        nRST = 1'b0;
        #1;
        vecs++; if ({oa, ob} !== {V_IDLE, V_IDLE}) begin errs++;
            $display("FAIL halt_rst got=%b exp=%b", oa, V_IDLE); end
        nRST = 1'b1;
        cyc();
    endtask

    task automatic test_random();
        ms_t ma, mb, na, nb, r0;
        logic [10:0] ea, eb;
        r0 = '{0, 0, 0, 0, 0};
        idle();
        nRST = 1'b0;
        ma = r0; mb = r0;
        cyc();
        nRST = 1'b1;
        for (int k = 0; k < 600; k++) begin
            ihit   = ($urandom % 8) != 0;
            dhit   = ($urandom % 4) != 0;
            meldst = ($urandom % 4) == 0;
            exld   = ($urandom % 3) == 0;
            rs     = 5'($urandom % 4);
            rt     = 5'($urandom % 4);
            exrdst = 5'($urandom % 4);
            merdst = 5'($urandom % 4);
            pcsrc  = 3'($urandom % 5);
            equal  = 1'($urandom % 2);
            halt   = ($urandom % 60) == 0;
            nRST   = ($urandom % 40) != 0;
            #2;
            if (!nRST) begin ma = r0; mb = r0; end
            mdl(ma, 2, 16, ea, na);
            mdl(mb, 3, 2, eb, nb);
            vecs++;
            if ({oa, sca, fca} !== {ea, 16'(ma.sc), 16'(ma.fc)}) begin
                errs++;
                $display("FAIL rand_a k=%0d got=%b/%0d/%0d exp=%b/%0d/%0d",
                         k, oa, sca, fca, ea, ma.sc, ma.fc);
            end
            vecs++;
            if ({ob, scb, fcb} !== {eb, 2'(mb.sc), 2'(mb.fc)}) begin
                errs++;
                $display("FAIL rand_b k=%0d got=%b/%0d/%0d exp=%b/%0d/%0d",
                         k, ob, scb, fcb, eb, mb.sc, mb.fc);
            end
            @(posedge CLK);
            #1;
            ma = nRST ? na : r0;
            mb = nRST ? nb : r0;
        end
        nRST = 1'b1;
        idle();
    endtask

    initial begin
        idle();
        nRST = 1'b0;
        test_reset();
        test_load_use();
        test_zero_reg();
        test_branch();
        test_jump();
        test_mem_stall();
        test_halt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
